k12a_lcd_sequencer: RTL

Sequences byte transfers to the HD44780-style character LCD so that software no longer has to bit-bang `lcd_en` through the control register. It sits between the I/O decode logic and the LCD pins. It queues register/data bytes in a small FIFO and runs the power-up initialisation sequence by itself. Each byte is then driven with correct setup, enable-pulse, hold and post-command wait timing, counted in `cpu_clock` cycles.

---
 rtl/k12a_lcd_sequencer_if.sv | 24 ++
 rtl/k12a_lcd_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/k12a_lcd_sequencer_if.sv
// Host-side write port and LCD pin bundle of the character-LCD sequencer.
// The host drives wr_*; the sequencer drives status and LCD pins.
interface k12a_lcd_sequencer_if;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       busy;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  modport master (
    output wr_valid, wr_rs, wr_data,
    input  wr_ready, busy, init_done, lcd_rs, lcd_rw, lcd_en, lcd_data
  );

  modport slave (
    input  wr_valid, wr_rs, wr_data,
    output wr_ready, busy, init_done, lcd_rs, lcd_rw, lcd_en, lcd_data
  );
endinterface

// File: rtl/k12a_lcd_sequencer.sv
// HD44780 byte sequencer: small FIFO, built-in power-up init, and timed
// setup / enable / hold / post-command wait driven by one shared down-counter.
//
//   state    | meaning
//   PWRUP    | power-up delay before the first init command
//   INIT     | load next init byte (rs=0) from the fixed list
//   IDLE     | pop a queued byte once init is done
//   SETUP    | rs/data stable, lcd_en low
//   ENABLE   | lcd_en high
//   HOLD     | lcd_en low, data held
//   WAIT     | post-command execution time (long for clear/home)
module k12a_lcd_sequencer #(
  parameter int SETUP_CYCLES = 1,
  parameter int EN_CYCLES    = 4,
  parameter int HOLD_CYCLES  = 1,
  parameter int WAIT_SHORT   = 40,
  parameter int WAIT_LONG    = 1600,
  parameter int INIT_WAIT    = 15000,
  parameter int FIFO_DEPTH   = 4
) (
  input logic                   cpu_clock,
  input logic                   reset_n,
  k12a_lcd_sequencer_if.slave   bus
);

  localparam int MAX_A = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int MAX_B = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int MAX_C = (MAX_B > WAIT_SHORT) ? MAX_B : WAIT_SHORT;
  localparam int MAX_D = (MAX_C > WAIT_LONG) ? MAX_C : WAIT_LONG;
  localparam int MAX_T = (MAX_D > INIT_WAIT) ? MAX_D : INIT_WAIT;
  localparam int CW    = $clog2(MAX_T + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int NW    = AW + 1;

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_SETUP, S_ENABLE, S_HOLD, S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    init_idx_q, init_idx_d;
  logic          init_done_q, init_done_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic [7:0]    lcd_data_q, lcd_data_d;
  logic          lcd_en_q, lcd_en_d;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0] count_q;

  logic       wr_ready, push, pop, long_wait;
  logic [8:0] head;
  logic [7:0] init_byte;

  assign wr_ready  = (count_q != NW'(FIFO_DEPTH));
  assign push      = bus.wr_valid & wr_ready;
  assign pop       = (state_q == S_IDLE) & init_done_q & (count_q != '0);
  assign head      = mem[rd_ptr_q];
  // Clear (0x01) and home (0x02/0x03) need the long execution time.
  assign long_wait = ~lcd_rs_q & (lcd_data_q[7:2] == 6'd0) & (lcd_data_q[1:0] != 2'd0);

  always_comb begin
    init_byte = 8'h01;
    case (init_idx_q[1:0])
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    case (state_q)
      S_PWRUP: if (cnt_q == '0) state_d = S_INIT;
      S_INIT: begin
        lcd_rs_d   = 1'b0;
        lcd_data_d = init_byte;
        init_idx_d = init_idx_q + 3'd1;
        cnt_d      = CW'(SETUP_CYCLES - 1);
        state_d    = S_SETUP;
      end
      S_IDLE: if (pop) begin
        lcd_rs_d   = head[8];
        lcd_data_d = head[7:0];
        cnt_d      = CW'(SETUP_CYCLES - 1);
        state_d    = S_SETUP;
      end
      S_SETUP: if (cnt_q == '0) begin
        cnt_d   = CW'(EN_CYCLES - 1);
        state_d = S_ENABLE;
      end
      S_ENABLE: if (cnt_q == '0) begin
        cnt_d   = CW'(HOLD_CYCLES - 1);
        state_d = S_HOLD;
      end
      S_HOLD: if (cnt_q == '0) begin
        cnt_d   = long_wait ? CW'(WAIT_LONG - 1) : CW'(WAIT_SHORT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: if (cnt_q == '0) begin
        if (!init_done_q && (init_idx_q != 3'd4)) begin
          state_d = S_INIT;
        end else begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_PWRUP;
    endcase
    lcd_en_d = (state_d == S_ENABLE);
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_PWRUP;
      cnt_q       <= CW'(INIT_WAIT - 1);
      init_idx_q  <= 3'd0;
      init_done_q <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
      lcd_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
      lcd_en_q    <= lcd_en_d;
    end
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge cpu_clock) begin
    if (push) mem[wr_ptr_q] <= {bus.wr_rs, bus.wr_data};
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.busy      = (state_q != S_IDLE) | (count_q != '0);
  assign bus.init_done = init_done_q;
  assign bus.lcd_rs    = lcd_rs_q;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_en    = lcd_en_q;
  assign bus.lcd_data  = lcd_data_q;

endmodule
